gpio_edge_irq: RTL

GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

---
 rtl/gpio_edge_irq_if.sv | 23 ++
 rtl/gpio_edge_irq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gpio_edge_irq_if.sv
// Memory-mapped slave bus for gpio_edge_irq: word-addressed register access
// with byte-lane writes and registered read data.
interface gpio_edge_irq_if;
  logic [2:0]  avs_gpio_address;
  logic [31:0] avs_gpio_writedata;
  logic [3:0]  avs_gpio_byteenable;
  logic        avs_gpio_write;
  logic        avs_gpio_read;
  logic [31:0] avs_gpio_readdata;
  logic        avs_gpio_waitrequest;

  modport master (
    output avs_gpio_address, avs_gpio_writedata, avs_gpio_byteenable,
           avs_gpio_write, avs_gpio_read,
    input  avs_gpio_readdata, avs_gpio_waitrequest
  );

  modport slave (
    input  avs_gpio_address, avs_gpio_writedata, avs_gpio_byteenable,
           avs_gpio_write, avs_gpio_read,
    output avs_gpio_readdata, avs_gpio_waitrequest
  );
endinterface

// File: rtl/gpio_edge_irq.sv
// 32-bit GPIO input block: synchronizer, edge detect, W1C capture, masked level irq.
// Optional per-pin debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_edge_irq #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic           csi_MCLK_clk,
  input  logic           rsi_MRST_reset,
  gpio_edge_irq_if.slave avs_gpio,
  input  logic [31:0]    coe_in,
  output logic           ins_irq_irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN = 3'd1;
  localparam logic [2:0] ADDR_FALL_EN = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_MASK    = 3'd4;

  logic [31:0] s1, s2, f, prev;
  logic [31:0] rise_en, fall_en, capture, irq_mask;
  logic [31:0] rise, fall, cap_set, w1c;
  logic [31:0] be_mask, rd_mux;
  logic        wr_rise, wr_fall, wr_cap, wr_mask;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] lanes);
    return (old & ~lanes) | (wd & lanes);
  endfunction

  assign avs_gpio.avs_gpio_waitrequest = 1'b0;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= coe_in;
      s2   <= s1;
      prev <= f;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] db_cnt [32];

  // f follows s2 only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      f <= '0;
      for (int i = 0; i < 32; i++) db_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (s2[i] == f[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] == DB_LAST) begin
          f[i]      <= s2[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  wire unused_ok = &{1'b0, avs_gpio.avs_gpio_read};
`else
  assign f = s2;

  wire unused_ok = &{1'b0, avs_gpio.avs_gpio_read, DEBOUNCE_CYCLES[0]};
`endif

  assign rise = f & ~prev;
  assign fall = ~f & prev;

  assign be_mask = {{8{avs_gpio.avs_gpio_byteenable[3]}}, {8{avs_gpio.avs_gpio_byteenable[2]}},
                    {8{avs_gpio.avs_gpio_byteenable[1]}}, {8{avs_gpio.avs_gpio_byteenable[0]}}};

  assign wr_rise = avs_gpio.avs_gpio_write && (avs_gpio.avs_gpio_address == ADDR_RISE_EN);
  assign wr_fall = avs_gpio.avs_gpio_write && (avs_gpio.avs_gpio_address == ADDR_FALL_EN);
  assign wr_cap  = avs_gpio.avs_gpio_write && (avs_gpio.avs_gpio_address == ADDR_CAPTURE);
  assign wr_mask = avs_gpio.avs_gpio_write && (avs_gpio.avs_gpio_address == ADDR_MASK);

  // set is OR-ed after the clear so a new edge wins over a same-cycle W1C
  assign cap_set = (rise & rise_en) | (fall & fall_en);
  assign w1c     = wr_cap ? (avs_gpio.avs_gpio_writedata & be_mask) : '0;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      rise_en     <= '0;
      fall_en     <= '0;
      capture     <= '0;
      irq_mask    <= '0;
      ins_irq_irq <= 1'b0;
    end else begin
      if (wr_rise) rise_en  <= merge(rise_en,  avs_gpio.avs_gpio_writedata, be_mask);
      if (wr_fall) fall_en  <= merge(fall_en,  avs_gpio.avs_gpio_writedata, be_mask);
      if (wr_mask) irq_mask <= merge(irq_mask, avs_gpio.avs_gpio_writedata, be_mask);
      capture     <= (capture & ~w1c) | cap_set;
      ins_irq_irq <= |(capture & irq_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_gpio.avs_gpio_address)
      ADDR_DATA:    rd_mux = f;
      ADDR_RISE_EN: rd_mux = rise_en;
      ADDR_FALL_EN: rd_mux = fall_en;
      ADDR_CAPTURE: rd_mux = capture;
      ADDR_MASK:    rd_mux = irq_mask;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) avs_gpio.avs_gpio_readdata <= '0;
    else                avs_gpio.avs_gpio_readdata <= rd_mux;
  end

endmodule
